// File: rtl/areset_gen_if.sv
// Board-reset signal bundle for areset_gen: MMCM lock/reset, push-button and sequencer status.
// The sequencer uses the master modport; whatever drives lock/button and observes the status uses slave.
interface areset_gen_if;
  logic       mmcm_locked;
  logic       button;
  logic       mmcm_reset;
  logic       areset;
  logic [7:0] retry_count;
  logic [1:0] state;

  modport master (
    input  mmcm_locked,
    input  button,
    output mmcm_reset,
    output areset,
    output retry_count,
    output state
  );

  modport slave (
    output mmcm_locked,
    output button,
    input  mmcm_reset,
    input  areset,
    input  retry_count,
    input  state
  );
endinterface

// File: rtl/areset_gen.sv
// areset_gen: board reset sequencer that pulses the MMCM reset and holds areset until lock is stable.
// Push-button restart (synchronizer, debounce, rising-edge event) exists only with ARESET_GEN_BUTTON_EN.
module areset_gen #(
  parameter int MMCM_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int BTN_DEBOUNCE_CYCLES = 1048576
) (
  input logic          clock,
  input logic          reset,
  areset_gen_if.master io
);
  localparam int MAX_A      = (MMCM_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? MMCM_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_B      = (LOCK_STABLE_CYCLES > BTN_DEBOUNCE_CYCLES) ? LOCK_STABLE_CYCLES : BTN_DEBOUNCE_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_MMCM_RST  = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  logic lock_meta_q, lock_meta_d;
  logic locked_s_q, locked_s_d;
  logic btn_evt;

  always_comb begin
    lock_meta_d = io.mmcm_locked;
    locked_s_d  = lock_meta_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      locked_s_q  <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      locked_s_q  <= locked_s_d;
    end
  end

`ifdef ARESET_GEN_BUTTON_EN
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(BTN_DEBOUNCE_CYCLES - 1);

  logic             btn_meta_q, btn_meta_d;
  logic             btn_s_q, btn_s_d;
  logic             btn_d_q, btn_d_d;
  logic             btn_prev_q, btn_prev_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

  // The debounced level only follows btn_s after an uninterrupted run of disagreement.
  always_comb begin
    btn_meta_d = io.button;
    btn_s_d    = btn_meta_q;
    btn_prev_d = btn_d_q;
    btn_d_d    = btn_d_q;
    db_cnt_d   = '0;
    if (btn_s_q != btn_d_q) begin
      if (db_cnt_q == DEB_LAST) begin
        btn_d_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      btn_d_q    <= 1'b0;
      btn_prev_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_s_q    <= btn_s_d;
      btn_d_q    <= btn_d_d;
      btn_prev_q <= btn_prev_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  assign btn_evt = btn_d_q & ~btn_prev_q;
`else
  logic button_unused;
  assign button_unused = io.button;
  assign btn_evt       = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             armed_q, armed_d;
  logic             mmcm_reset_q, mmcm_reset_d;
  logic             areset_q, areset_d;

  // The first edge after reset release only arms the sequencer, so the power-on MMCM pulse
  // never depends on an edge that may violate reset recovery.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    armed_d = 1'b1;
    if (!armed_q) begin
      cnt_d = cnt_q;
    end else if (btn_evt) begin
      state_d = S_MMCM_RST;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_MMCM_RST: begin
          if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s_q) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = S_MMCM_RST;
            if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
          end
        end
        S_STABLE: begin
          if (!locked_s_q)                state_d = S_WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          cnt_d = cnt_q;
          if (!locked_s_q) state_d = S_MMCM_RST;
        end
        default: state_d = S_MMCM_RST;
      endcase
      if (state_d != state_q) cnt_d = '0;
    end
    mmcm_reset_d = (state_d == S_MMCM_RST);
    areset_d     = (state_d != S_RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_MMCM_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      armed_q      <= 1'b0;
      mmcm_reset_q <= 1'b1;
      areset_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      armed_q      <= armed_d;
      mmcm_reset_q <= mmcm_reset_d;
      areset_q     <= areset_d;
    end
  end

  assign io.mmcm_reset  = mmcm_reset_q;
  assign io.areset      = areset_q;
  assign io.retry_count = retry_q;
  assign io.state       = state_q;
endmodule

// File: tb/tb_areset_gen.sv
// Directed bench for areset_gen with small sequencing parameters; expectations follow the
// edge-by-edge timeline where edge 0 is the first clock edge after reset release.
module tb_areset_gen;
  logic clock;
  logic reset;

  areset_gen_if bus ();

  areset_gen #(
    .MMCM_RST_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .BTN_DEBOUNCE_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (bus)
  );

`ifdef ARESET_GEN_BUTTON_EN
  localparam bit BTN_EN = 1'b1;
`else
  localparam bit BTN_EN = 1'b0;
`endif

  int         n_tests;
  int         n_fail;
  logic [1:0] exp_st;
  logic       exp_mr;
  logic       exp_ar;
  logic [7:0] exp_rc;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input logic locked);
    reset           = 1'b1;
    bus.mmcm_locked = locked;
    bus.button      = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.mmcm_locked = 1'b1;
    bus.button      = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_tests++; if (bus.state !== 2'd0)       begin n_fail++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    n_tests++; if (bus.mmcm_reset !== 1'b1)  begin n_fail++; $display("FAIL reset_mmcm_reset got=%b exp=1", bus.mmcm_reset); end
    n_tests++; if (bus.areset !== 1'b1)      begin n_fail++; $display("FAIL reset_areset got=%b exp=1", bus.areset); end
    n_tests++; if (bus.retry_count !== 8'd0) begin n_fail++; $display("FAIL reset_retry got=%0d exp=0", bus.retry_count); end
  endtask

  task automatic test_startup();
    apply_reset(1'b1);
    for (int e = 0; e <= 15; e++) begin
      step();
      if (e < 4)       exp_st = 2'd0;
      else if (e == 4) exp_st = 2'd1;
      else if (e < 13) exp_st = 2'd2;
      else             exp_st = 2'd3;
      exp_mr = (e < 4);
      exp_ar = (e < 13);
      n_tests++; if (bus.state !== exp_st)      begin n_fail++; $display("FAIL startup_state e=%0d got=%0d exp=%0d", e, bus.state, exp_st); end
      n_tests++; if (bus.mmcm_reset !== exp_mr) begin n_fail++; $display("FAIL startup_mmcm_reset e=%0d got=%b exp=%b", e, bus.mmcm_reset, exp_mr); end
      n_tests++; if (bus.areset !== exp_ar)     begin n_fail++; $display("FAIL startup_areset e=%0d got=%b exp=%b", e, bus.areset, exp_ar); end
    end
    n_tests++; if (bus.retry_count !== 8'd0) begin n_fail++; $display("FAIL startup_retry got=%0d exp=0", bus.retry_count); end
  endtask

  // Without lock: WAIT_LOCK from edge 4, then MMCM_RST re-entered every 36 edges (36, 72, ...).
  task automatic test_timeout();
    apply_reset(1'b0);
    for (int e = 0; e <= 36 * 300 + 8; e++) begin
      step();
      if (e < 4) exp_st = 2'd0;
      else       exp_st = (((e - 4) % 36) < 32) ? 2'd1 : 2'd0;
      exp_rc = ((e / 36) > 255) ? 8'd255 : 8'(e / 36);
      n_tests++; if (bus.state !== exp_st)       begin n_fail++; $display("FAIL timeout_state e=%0d got=%0d exp=%0d", e, bus.state, exp_st); end
      n_tests++; if (bus.retry_count !== exp_rc) begin n_fail++; $display("FAIL timeout_retry e=%0d got=%0d exp=%0d", e, bus.retry_count, exp_rc); end
    end
  endtask

  task automatic test_flicker();
    apply_reset(1'b1);
    for (int e = 0; e <= 40; e++) begin
      step();
      if (e < 4)       exp_st = 2'd0;
      else if (e == 4) exp_st = 2'd1;
      else if (e < 9)  exp_st = 2'd2;
      else if (e == 9) exp_st = 2'd1;
      else if (e < 18) exp_st = 2'd2;
      else if (e < 23) exp_st = 2'd3;
      else if (e < 27) exp_st = 2'd0;
      else if (e == 27) exp_st = 2'd1;
      else if (e < 36) exp_st = 2'd2;
      else             exp_st = 2'd3;
      exp_mr = (exp_st == 2'd0);
      exp_ar = (exp_st != 2'd3);
      n_tests++; if (bus.state !== exp_st)      begin n_fail++; $display("FAIL flicker_state e=%0d got=%0d exp=%0d", e, bus.state, exp_st); end
      n_tests++; if (bus.mmcm_reset !== exp_mr) begin n_fail++; $display("FAIL flicker_mmcm_reset e=%0d got=%b exp=%b", e, bus.mmcm_reset, exp_mr); end
      n_tests++; if (bus.areset !== exp_ar)     begin n_fail++; $display("FAIL flicker_areset e=%0d got=%b exp=%b", e, bus.areset, exp_ar); end
      if (e == 6 || e == 20) bus.mmcm_locked = 1'b0;
      if (e == 7 || e == 21) bus.mmcm_locked = 1'b1;
    end
  endtask

  task automatic test_button();
    int   rises;
    logic prev_ar;
    apply_reset(1'b0);
    for (int e = 0; e <= 55; e++) begin
      step();
      if (e == 36) bus.mmcm_locked = 1'b1;
    end
    n_tests++; if (bus.state !== 2'd3)       begin n_fail++; $display("FAIL button_pre_state got=%0d exp=3", bus.state); end
    n_tests++; if (bus.retry_count !== 8'd1) begin n_fail++; $display("FAIL button_pre_retry got=%0d exp=1", bus.retry_count); end
    // Bounce with 5-cycle phases, ending low long enough to clear the debounce run.
    for (int t = 0; t < 34; t++) begin
      bus.button = (t < 30) && (((t / 5) % 2) == 0);
      step();
      n_tests++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL button_bounce_state t=%0d got=%0d exp=3", t, bus.state); end
    end
    rises   = 0;
    prev_ar = bus.areset;
    for (int k = 0; k < 72; k++) begin
      bus.button = (k < 40);
      step();
      if (BTN_EN) exp_ar = (k >= 18) && (k < 31);
      else        exp_ar = 1'b0;
      n_tests++; if (bus.areset !== exp_ar) begin n_fail++; $display("FAIL button_areset k=%0d got=%b exp=%b", k, bus.areset, exp_ar); end
      if (bus.areset === 1'b1 && prev_ar === 1'b0) rises++;
      prev_ar = bus.areset;
    end
    n_tests++; if (rises !== (BTN_EN ? 1 : 0)) begin n_fail++; $display("FAIL button_restarts got=%0d exp=%0d", rises, BTN_EN ? 1 : 0); end
    n_tests++; if (bus.retry_count !== 8'd1)   begin n_fail++; $display("FAIL button_retry got=%0d exp=1", bus.retry_count); end
    n_tests++; if (bus.state !== 2'd3)         begin n_fail++; $display("FAIL button_post_state got=%0d exp=3", bus.state); end
  endtask

  task automatic test_async_reset();
    apply_reset(1'b1);
    for (int e = 0; e <= 7; e++) step();
    n_tests++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL async_pre_stable got=%0d exp=2", bus.state); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (bus.state !== 2'd0)      begin n_fail++; $display("FAIL async_stable_state got=%0d exp=0", bus.state); end
    n_tests++; if (bus.mmcm_reset !== 1'b1) begin n_fail++; $display("FAIL async_stable_mmcm_reset got=%b exp=1", bus.mmcm_reset); end
    n_tests++; if (bus.areset !== 1'b1)     begin n_fail++; $display("FAIL async_stable_areset got=%b exp=1", bus.areset); end
    @(negedge clock);
    reset = 1'b0;
    for (int e = 0; e <= 15; e++) step();
    n_tests++; if (bus.state !== 2'd3)  begin n_fail++; $display("FAIL async_pre_run got=%0d exp=3", bus.state); end
    n_tests++; if (bus.areset !== 1'b0) begin n_fail++; $display("FAIL async_pre_run_areset got=%b exp=0", bus.areset); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (bus.state !== 2'd0)      begin n_fail++; $display("FAIL async_run_state got=%0d exp=0", bus.state); end
    n_tests++; if (bus.mmcm_reset !== 1'b1) begin n_fail++; $display("FAIL async_run_mmcm_reset got=%b exp=1", bus.mmcm_reset); end
    n_tests++; if (bus.areset !== 1'b1)     begin n_fail++; $display("FAIL async_run_areset got=%b exp=1", bus.areset); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus.mmcm_locked = 1'b0;
    bus.button      = 1'b0;
    test_reset();
    test_startup();
    test_timeout();
    test_flicker();
    test_button();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
